// File: rtl/priority_grant_decoder.sv
// priority_grant_decoder
// Turns the priority encoder's {code, valid} result back into a registered
// one-hot grant. The grant is held until the owning agent acks it or the
// hold counter expires. One extra request can wait in a 1-deep pending slot
// while a grant is outstanding, and it is handed over with no idle bubble.
module priority_grant_decoder #(
  parameter int CODE_W  = 2,
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CODE_W-1:0]    in_code,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 ack,
  output logic [2**CODE_W-1:0] grant,
  output logic [CODE_W-1:0]    grant_code,
  output logic                 busy,
  output logic                 timeout,
  output logic [7:0]           to_count
);

  localparam int GW = 2**CODE_W;

  // Counter value seen on the last cycle a grant may be held without ack.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t            state;
  logic              pend_valid;
  logic [CODE_W-1:0] pend_code;
  logic [CNT_W-1:0]  hold_cnt;

  logic              accept;
  logic              hold_done;
  logic              drop;
  logic              expire;

  // Binary index to one-hot grant vector.
  function automatic logic [GW-1:0] onehot(input logic [CODE_W-1:0] c);
    logic [GW-1:0] r;
    r    = '0;
    r[c] = 1'b1;
    return r;
  endfunction

  // Timeout statistics stick at the top of the 8-bit range.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Ready depends only on the pending slot, so there is no in_valid->in_ready path.
  assign in_ready  = ~pend_valid;
  assign accept    = in_valid & in_ready;
  assign hold_done = (hold_cnt == HOLD_LAST);
  // A grant ends on ack or on expiry; ack takes precedence over expiry.
  assign drop      = (state == GRANT) & (ack | hold_done);
  assign expire    = (state == GRANT) & ~ack & hold_done;

  // Grant FSM with registered outputs, pending slot, hold counter and statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= '0;
      grant_code <= '0;
      busy       <= 1'b0;
      timeout    <= 1'b0;
      to_count   <= 8'd0;
      pend_valid <= 1'b0;
      pend_code  <= '0;
      hold_cnt   <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (pend_valid) begin
            state      <= GRANT;
            grant      <= onehot(pend_code);
            grant_code <= pend_code;
            busy       <= 1'b1;
            hold_cnt   <= '0;
            pend_valid <= 1'b0;
          end else if (accept) begin
            state      <= GRANT;
            grant      <= onehot(in_code);
            grant_code <= in_code;
            busy       <= 1'b1;
            hold_cnt   <= '0;
          end
        end
        GRANT: begin
          if (drop) begin
            if (expire) begin
              timeout  <= 1'b1;
              to_count <= sat_inc(to_count);
            end
            // Hand the next request over on the same edge so the grant never bubbles.
            if (pend_valid) begin
              grant      <= onehot(pend_code);
              grant_code <= pend_code;
              hold_cnt   <= '0;
              pend_valid <= 1'b0;
            end else if (accept) begin
              grant      <= onehot(in_code);
              grant_code <= in_code;
              hold_cnt   <= '0;
            end else begin
              state      <= IDLE;
              grant      <= '0;
              grant_code <= '0;
              busy       <= 1'b0;
              hold_cnt   <= '0;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
            if (accept) begin
              pend_valid <= 1'b1;
              pend_code  <= in_code;
            end
          end
        end
        default: begin
          state      <= IDLE;
          grant      <= '0;
          grant_code <= '0;
          busy       <= 1'b0;
          hold_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_priority_grant_decoder.sv
// Bench for priority_grant_decoder: directed stimulus, a queue-based
// behavioural model compared on every falling edge, and literal spot checks.
module tb_priority_grant_decoder;

  localparam int TIMEOUT = 8;

  logic       clk;
  logic       rst_n;
  logic [1:0] in_code;
  logic       in_valid;
  logic       in_ready;
  logic       ack;
  logic [3:0] grant;
  logic [1:0] grant_code;
  logic       busy;
  logic       timeout;
  logic [7:0] to_count;

  int n_checks = 0;
  int n_fail   = 0;

  priority_grant_decoder #(.CODE_W(2), .TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_code    (in_code),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ack        (ack),
    .grant      (grant),
    .grant_code (grant_code),
    .busy       (busy),
    .timeout    (timeout),
    .to_count   (to_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: owner of the grant (-1 = none), cycles it has been visible,
  // queue of waiting requests, timeout pulse and timeout tally.
  int cur;
  int age;
  int pq[$];
  bit tout_m;
  int to_m;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur = -1; age = 0; pq.delete(); tout_m = 0; to_m = 0;
    end else begin
      bit acc;
      acc    = in_valid && (pq.size() == 0);
      tout_m = 0;
      if (cur < 0) begin
        if (pq.size() > 0) begin cur = pq.pop_front(); age = 1; end
        else if (acc) begin cur = int'(in_code); age = 1; end
      end else if (ack || age == TIMEOUT) begin
        if (!ack) begin
          tout_m = 1;
          if (to_m < 255) to_m++;
        end
        if (pq.size() > 0) begin cur = pq.pop_front(); age = 1; end
        else if (acc) begin cur = int'(in_code); age = 1; end
        else begin cur = -1; age = 0; end
      end else begin
        age++;
        if (acc) pq.push_back(int'(in_code));
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("grant",      int'(grant),      (cur < 0) ? 0 : (1 << cur));
    chk("grant_code", int'(grant_code), (cur < 0) ? 0 : cur);
    chk("busy",       int'(busy),       (cur < 0) ? 0 : 1);
    chk("in_ready",   int'(in_ready),   (pq.size() == 0) ? 1 : 0);
    chk("timeout",    int'(timeout),    int'(tout_m));
    chk("to_count",   int'(to_count),   to_m);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hi_cnt;
    int to_seen;
    rst_n = 1'b0; in_valid = 1'b1; in_code = 2'd2; ack = 1'b0;
    #23;
    chk("rst_grant", int'(grant), 0);
    chk("rst_ready", int'(in_ready), 1);
    chk("rst_busy",  int'(busy), 0);
    step();
    in_valid = 1'b0;
    rst_n    = 1'b1;
    repeat (5) step();
    chk("idle_grant", int'(grant), 0);
    chk("idle_busy",  int'(busy), 0);

    // Single grant, acked on the third grant cycle.
    in_code = 2'd2; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("g2_grant", int'(grant), 4);
    chk("g2_code",  int'(grant_code), 2);
    chk("g2_busy",  int'(busy), 1);
    step(); step();
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("g2_rel_grant",   int'(grant), 0);
    chk("g2_rel_timeout", int'(timeout), 0);
    step();
    chk("g2_to_count", int'(to_count), 0);

    // Timeout: code 3 held exactly TIMEOUT cycles with one pulse.
    in_code = 2'd3; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    hi_cnt = 0; to_seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (grant == 4'b1000) hi_cnt++;
      if (timeout) to_seen++;
      step();
    end
    chk("to_hold_cycles", hi_cnt, 8);
    chk("to_pulses",      to_seen, 1);
    chk("to_count_1",     int'(to_count), 1);

    // Back-to-back with pending slot.
    in_code = 2'd1; in_valid = 1'b1;
    step();
    chk("bb_first", int'(grant), 2);
    in_code = 2'd0;
    step();
    chk("bb_pend_ready", int'(in_ready), 0);
    in_code = 2'd3;
    step();
    chk("bb_held_ready", int'(in_ready), 0);
    chk("bb_held_grant", int'(grant), 2);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("bb_handoff", int'(grant), 1);
    chk("bb_ready_back", int'(in_ready), 1);
    step();
    in_valid = 1'b0;
    chk("bb_third_pend", int'(in_ready), 0);
    ack = 1'b1;
    step();
    chk("bb_third_grant", int'(grant), 8);
    step();
    ack = 1'b0;
    chk("bb_drained", int'(grant), 0);

    // Ack while idle is ignored.
    ack = 1'b1;
    step(); step();
    ack = 1'b0;
    chk("idle_ack", int'(grant), 0);

    // Ack on the expiry cycle: ack wins.
    in_code = 2'd0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (7) step();
    chk("exp_still_held", int'(grant), 1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("exp_rel_grant",   int'(grant), 0);
    chk("exp_rel_timeout", int'(timeout), 0);
    chk("exp_to_count",    int'(to_count), 1);
    step();

    // Async reset mid-grant with the pending slot full.
    in_code = 2'd2; in_valid = 1'b1;
    step();
    in_code = 2'd1;
    step();
    in_valid = 1'b0;
    chk("ar_pre_ready", int'(in_ready), 0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_grant",    int'(grant), 0);
    chk("ar_busy",     int'(busy), 0);
    chk("ar_ready",    int'(in_ready), 1);
    chk("ar_to_count", int'(to_count), 0);
    #1;
    rst_n = 1'b1;
    repeat (3) step();
    chk("ar_after_grant", int'(grant), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
